lag_pl_buffer_bank: RTL and testbench
=====================================

// Module: lag_pl_buffer_bank
// PURPOSE
//  Bank of n independent FIFO flit buffers, one per physical lane (PL), at a router input port.
//  Upstream pushes flits per lane. Downstream (switch/PL allocation) reads each lane's head flit and pops it.
//  Per-lane status flags drive flow control (credits) and allocation.
// PARAMETERS
//  size  8  depth of each lane FIFO in flits; legal range >= 2, any integer (need not be a power of 2)
//  n     4  number of lanes (independent FIFOs)
// PORTS
//  clk       in   1                  sole clock; all state updates on rising edge
//  rst_n     in   1                  reset; asynchronous, active-high (port name kept for interface compatibility)
//  push      in   [n-1:0]            push[i]=1 writes data_in[i] into lane i this cycle
//  pop       in   [n-1:0]            pop[i]=1 removes head flit of lane i this cycle
//  data_in   in   flit_t [n-1:0]     flit to write, per lane
//  data_out  out  flit_t [n-1:0]     current head flit of each lane (first-word fall-through)
//  flags     out  fifov_flags_t [n-1:0]  per lane: full, empty, nearly_full, nearly_empty
// BEHAVIOUR
//  - Lanes are fully independent; no cross-lane interaction.
//  - State per lane: storage[size], rd_ptr, wr_ptr, count (0..size).
//  - Pointer wrap: each pointer increments modulo size (size-1 -> 0).
//  - Reset (async, rst_n=1): rd_ptr=wr_ptr=count=0 in every lane. Storage is not cleared.
//    Outputs during/after reset: empty=1, nearly_empty=1, full=0, nearly_full=0 (size>2), data_out='0.
//  - Push: accepted if count<size, or if count==size and pop is accepted in the same cycle.
//    On accept: storage[wr_ptr]<=data_in, wr_ptr++. A push to a full lane without pop is dropped; state unchanged.
//  - Pop: accepted only if count>0; on accept rd_ptr++. Pop on an empty lane is ignored.
//  - Simultaneous accepted push+pop: count unchanged, both pointers advance.
//    Push+pop on an empty lane: push accepted, pop ignored, count 0->1.
//  - Latency: a flit pushed in cycle t is visible on data_out from t+1 when the lane was empty.
//    data_out is combinational from storage[rd_ptr], forced to '0 when count==0.
//  - Flags are combinational from registered count (no bypass from push/pop in same cycle):
//    empty=(count==0), full=(count==size), nearly_empty=(count<=1), nearly_full=(count>=size-1).
//  - Reset mid-operation discards all buffered flits immediately (asynchronous).
// CONFIGURATION
//  LAG_PL_BUF_ASSERT_EN defined:
//    - simulation assertions: $error on push to a full lane without a same-cycle pop (overflow).
//    - $error on pop of an empty lane (underflow).
//    - Functional behaviour is identical in both builds.
//  Not defined: no assertions; illegal push/pop silently ignored as above.
// STRUCTURE
//  Shared package (LAG_pkg): flit_t, including control.head/control.tail.
//    fifov_flags_t {full, empty, nearly_full, nearly_empty}.
//  Sub-module: lag_pl_fifo (single-lane FWFT FIFO with flags), instantiated n times via generate loop.
//    Top level only wires the per-lane slices.
// TESTING
//  1 Reset then idle -> all lanes empty=1, nearly_empty=1, full=0, data_out='0.
//  2 Push flits A,B,C into lane 0 on consecutive cycles, no pops:
//    data_out[0]=A from cycle after first push; count 3; lanes 1..3 stay empty.
//  3 Fill lane 2 with 8 pushes (size=8):
//    nearly_full after 7, full after 8; 9th push dropped; 8 pops return flits in order, then empty=1.
//  4 Full lane + push+pop same cycle -> full stays 1; head advances; new flit appears last.
//    Wrap-around order preserved over 3*size flits.
//  5 Empty lane + push+pop same cycle -> pop ignored, count=1, data_out=pushed flit next cycle.
//  6 Assert reset while lanes 1 and 3 hold flits -> immediately empty; post-reset pushes start at clean state.

Source files
------------

// File: rtl/lag_pl_buffer_bank_pkg.sv
// Shared flit and FIFO status types for the physical-lane buffer bank.
// Optional build macro used by the lane FIFO: LAG_PL_BUF_ASSERT_EN.
package LAG_pkg;

    localparam int FLIT_DATA_W = 16;

    typedef struct packed {
        logic head;
        logic tail;
    } flit_ctrl_t;

    typedef struct packed {
        flit_ctrl_t             control;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic nearly_full;
        logic nearly_empty;
    } fifov_flags_t;

endpackage

// File: rtl/lag_pl_buffer_bank_fifo.sv
// Single-lane first-word-fall-through flit FIFO with occupancy flags.
// Define LAG_PL_BUF_ASSERT_EN to bind overflow/underflow checks to each lane.
`ifdef LAG_PL_BUF_ASSERT_EN
module lag_pl_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst_n) !(push && full && !pop))
        else $error("lag_pl_fifo: push to full lane without pop");

    a_no_underflow: assert property (@(posedge clk) disable iff (rst_n) !(pop && empty))
        else $error("lag_pl_fifo: pop of empty lane");
endmodule
`endif

module lag_pl_fifo
    import LAG_pkg::*;
#(
    parameter int size = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  flit_t        data_in,
    output flit_t        data_out,
    output fifov_flags_t flags
);
    localparam int PTR_W = $clog2(size);
    localparam int CNT_W = $clog2(size + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    flit_t            storage_q [size];
    logic             push_ok, pop_ok, is_full, is_empty;

    // Sizes need not be powers of two, so wrap explicitly at size-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(size - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Accept logic and next-state pointers/count.
    always_comb begin
        is_empty = (count_q == CNT_W'(0));
        is_full  = (count_q == CNT_W'(size));
        pop_ok   = pop & ~is_empty;
        push_ok  = push & (~is_full | pop_ok);
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; storage is deliberately left uncleared.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            storage_q[wr_ptr_q] <= data_in;
        end
    end

    // Head flit and flags from registered state only.
    always_comb begin
        if (is_empty) begin
            data_out = {$bits(flit_t){1'b0}};
        end else begin
            data_out = storage_q[rd_ptr_q];
        end
        flags.full         = is_full;
        flags.empty        = is_empty;
        flags.nearly_full  = (count_q >= CNT_W'(size - 1));
        flags.nearly_empty = (count_q <= CNT_W'(1));
    end

`ifdef LAG_PL_BUF_ASSERT_EN
    lag_pl_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (is_full),
        .empty (is_empty)
    );
`endif

endmodule

// File: rtl/lag_pl_buffer_bank.sv
// Router input-port bank of n independent physical-lane flit FIFOs.
// Build option LAG_PL_BUF_ASSERT_EN enables per-lane overflow/underflow checks.
module lag_pl_buffer_bank
    import LAG_pkg::*;
#(
    parameter int size = 8,
    parameter int n    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [n-1:0]           push,
    input  logic [n-1:0]           pop,
    input  flit_t [n-1:0]          data_in,
    output flit_t [n-1:0]          data_out,
    output fifov_flags_t [n-1:0]   flags
);

    for (genvar i = 0; i < n; i++) begin : g_lane
        lag_pl_fifo #(
            .size (size)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .pop      (pop[i]),
            .data_in  (data_in[i]),
            .data_out (data_out[i]),
            .flags    (flags[i])
        );
    end

endmodule

// File: tb/tb_lag_pl_buffer_bank.sv
// Directed self-checking bench for lag_pl_buffer_bank (size=8, n=4).
module tb_lag_pl_buffer_bank;
    import LAG_pkg::*;

    localparam int SIZE = 8;
    localparam int N    = 4;

    // flags packing is {full, empty, nearly_full, nearly_empty}
    localparam logic [3:0] F_EMPTY = 4'b0101;
    localparam logic [3:0] F_ONE   = 4'b0001;
    localparam logic [3:0] F_MID   = 4'b0000;
    localparam logic [3:0] F_NFULL = 4'b0010;
    localparam logic [3:0] F_FULL  = 4'b1010;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         push;
    logic [N-1:0]         pop;
    flit_t [N-1:0]        data_in;
    flit_t [N-1:0]        data_out;
    fifov_flags_t [N-1:0] flags;

    int n_vec;
    int n_err;

    lag_pl_buffer_bank #(.size(SIZE), .n(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mkf(input logic [15:0] d);
        flit_t f;
        f.control.head = d[0];
        f.control.tail = d[1];
        f.data         = d;
        return f;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input int l, input logic [3:0] ef, input flit_t ed);
        check_eq($sformatf("%s.flags[%0d]", tag, l), 32'(flags[l]), 32'(ef));
        check_eq($sformatf("%s.data[%0d]", tag, l), 32'(data_out[l]), 32'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = '0;
        pop  = '0;
    endtask

    flit_t zero_f;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        zero_f  = mkf(16'h0000);
        zero_f.control = 2'b00;
        rst_n   = 1'b1;
        push    = '0;
        pop     = '0;
        data_in = '0;

        // 1: reset and idle
        #12;
        for (int l = 0; l < N; l++) check_lane("in_reset", l, F_EMPTY, zero_f);
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        for (int l = 0; l < N; l++) check_lane("idle", l, F_EMPTY, zero_f);

        // 2: A,B,C into lane 0
        push = 4'b0001; data_in[0] = mkf(16'h00A1); tick();
        check_lane("pushA", 0, F_ONE, mkf(16'h00A1));
        data_in[0] = mkf(16'h00B2); tick();
        check_lane("pushB", 0, F_MID, mkf(16'h00A1));
        data_in[0] = mkf(16'h00C3); tick();
        idle();
        check_lane("pushC", 0, F_MID, mkf(16'h00A1));
        for (int l = 1; l < N; l++) check_lane("others_empty", l, F_EMPTY, zero_f);

        // 3: fill lane 2, overflow drop, drain in order
        push = 4'b0100;
        for (int k = 0; k < SIZE; k++) begin
            data_in[2] = mkf(16'h0020 + 16'(k));
            tick();
            if (k == SIZE - 2) check_lane("fill7", 2, F_NFULL, mkf(16'h0020));
        end
        check_lane("fill8", 2, F_FULL, mkf(16'h0020));
        data_in[2] = mkf(16'h0099); tick();
        idle();
        check_lane("overflow", 2, F_FULL, mkf(16'h0020));
        pop = 4'b0100;
        for (int k = 0; k < SIZE; k++) begin
            check_eq($sformatf("drain2_%0d", k), 32'(data_out[2]), 32'(mkf(16'h0020 + 16'(k))));
            tick();
        end
        idle();
        check_lane("drained2", 2, F_EMPTY, zero_f);
        check_lane("lane0_kept", 0, F_MID, mkf(16'h00A1));

        // 4: full lane 1 with push+pop, 3*size flits through with wrap
        push = 4'b0010;
        for (int k = 0; k < SIZE; k++) begin
            data_in[1] = mkf(16'h0040 + 16'(k));
            tick();
        end
        pop = 4'b0010;
        for (int j = 0; j < 2 * SIZE; j++) begin
            if (j < SIZE) check_eq($sformatf("pp_head_%0d", j), 32'(data_out[1]), 32'(mkf(16'h0040 + 16'(j))));
            else          check_eq($sformatf("pp_head_%0d", j), 32'(data_out[1]), 32'(mkf(16'h0050 + 16'(j - SIZE))));
            data_in[1] = mkf(16'h0050 + 16'(j));
            tick();
            check_eq($sformatf("pp_full_%0d", j), 32'(flags[1]), 32'(F_FULL));
        end
        push = 4'b0000;
        for (int k = 0; k < SIZE; k++) begin
            check_eq($sformatf("wrap_drain_%0d", k), 32'(data_out[1]), 32'(mkf(16'h0058 + 16'(k))));
            tick();
        end
        idle();
        check_lane("wrap_empty", 1, F_EMPTY, zero_f);

        // 5: push+pop on empty lane 3
        push = 4'b1000; pop = 4'b1000; data_in[3] = mkf(16'h0077); tick();
        idle();
        check_lane("pp_empty", 3, F_ONE, mkf(16'h0077));

        // 6: async reset with flits in lanes 1 and 3
        push = 4'b0010; data_in[1] = mkf(16'h0061); tick();
        idle();
        check_lane("pre_rst", 1, F_ONE, mkf(16'h0061));
        #2 rst_n = 1'b1;
        #1;
        check_lane("async_rst", 1, F_EMPTY, zero_f);
        check_lane("async_rst", 3, F_EMPTY, zero_f);
        check_lane("async_rst", 0, F_EMPTY, zero_f);
        @(negedge clk);
        rst_n = 1'b0;
        push = 4'b0010; data_in[1] = mkf(16'h0062); tick();
        idle();
        check_lane("post_rst", 1, F_ONE, mkf(16'h0062));
        tick();
        check_lane("post_rst_hold", 1, F_ONE, mkf(16'h0062));
        check_lane("post_rst_l3", 3, F_EMPTY, zero_f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
